count_sequencer: RTL
====================

Name: count_sequencer

Overview:
Controller that sequences a WIDTH-bit event counter for the counter datapath family.
- Runs the counter from 0 up to a programmable terminal value, in one-shot or periodic mode.
- Provides start, halt and hold control.
- Flags each terminal-count event and counts completed periods.
- Sits between software/control logic and the counter outputs, replacing free-running ripple operation with a fully synchronous, controllable sequence.

Parameters:
WIDTH, 4, counter width in bits
PCNT_W, 8, width of completed-period counter

Ports:
clock  input  1  single system clock, all state updates on rising edge
clear  input  1  asynchronous active-low reset
start  input  1  begin a count sequence (sampled in IDLE or DONE only)
halt  input  1  abort sequence, return to IDLE
hold  input  1  freeze counting while high (RUN/HOLD only)
periodic  input  1  1 = reload at terminal and continue; 0 = one-shot
terminal  input  WIDTH  terminal count value, latched on accepted start
q  output  WIDTH  current count
busy  output  1  high in RUN or HOLD
tc  output  1  one-cycle pulse per terminal-count event
done  output  1  high while in DONE (one-shot complete)
periods  output  PCNT_W  number of completed periodic wraps, saturating

Behaviour:
- Reset: clock and reset are as decided: one clock (clock); reset clear is asynchronous and active-low. clear=0 forces, immediately and independent of clock:
  - state=IDLE
  - q=0, term_r=0, periods=0
  - tc=0, done=0, busy=0
  - Applies mid-sequence too; no partial update survives.
- States: IDLE, RUN, HOLD, DONE. Encoding is free. busy and done are decoded from state (registered state, no input-to-output comb path).
- Priority in every state: halt > start > hold > count.
- IDLE:
  - start=1 -> q<=0, term_r<=terminal, periods<=0, state<=RUN.
  - Otherwise all values hold.
  - hold and periodic are ignored.
- RUN, each edge:
  - halt=1 -> state<=IDLE, q<=0; periods retained.
  - Else hold=1 -> state<=HOLD; q unchanged.
  - Else if q==term_r -> terminal event: tc<=1 on this edge (high for exactly the following cycle).
    - periodic=1: q<=0, periods<=periods+1, saturating at all-ones; stay RUN.
    - periodic=0: q holds term_r, state<=DONE.
  - Else q<=q+1, tc<=0.
- periodic is sampled live at each terminal event, not latched.
- HOLD:
  - q, term_r, periods frozen; tc<=0.
  - halt=1 -> IDLE, q<=0.
  - hold=0 -> RUN; counting resumes on the next edge after the one that re-enters RUN.
- DONE:
  - done=1, q=term_r, tc<=0.
  - start=1 -> same action as start in IDLE (restart, done drops).
  - halt=1 -> IDLE, q<=0.
  - hold ignored.
- start while RUN/HOLD: ignored; terminal changes after latch have no effect.
- tc is 0 on every edge not listed as a terminal event.
- Latency:
  - start edge -> q=0 in RUN.
  - First increment on next edge.
  - Terminal event N = term_r+1 RUN cycles after start.
- Boundaries:
  - terminal=0, periodic: q stays 0, tc high every RUN cycle, periods increments every cycle until saturation.
  - terminal=0, one-shot: DONE one edge after entering RUN.
  - terminal=2^WIDTH-1: q reaches all-ones; periodic reload to 0 by the reload rule, not by overflow.
  - periods saturates at 2^PCNT_W-1; no wrap.
  - Simultaneous hold and terminal match: hold wins, and the event occurs after resume.
  - Simultaneous halt and any other input: halt wins, tc<=0.

Test Plan:
- Reset/one-shot: assert clear=0 mid-RUN -> q=0, busy=0, done=0, tc=0 immediately. Release, terminal=5, periodic=0, pulse start -> q 0,1,2,3,4,5; tc high one cycle after q=5 sampled; done=1, q holds 5, busy=0.
- Periodic: terminal=3, periodic=1, start -> q 0,1,2,3,0,1,2,3,...; tc pulse every 4 cycles; periods=1,2,3 after the 1st, 2nd, 3rd wrap; busy stays 1.
- Hold: terminal=9, hold=1 for 3 cycles at q=4 -> q stays 4, busy=1, tc=0. Release -> q 5..9 continues; total RUN cycles to tc unchanged.
- Halt/start priority: at q=6, assert halt and start together -> IDLE, q=0, busy=0. start alone during RUN with a new terminal -> ignored, original term_r used.
- Edge values: terminal=0 periodic -> tc continuously high, periods counts 1,2,3. WIDTH=4, terminal=15 periodic -> q 15->0 reload with tc. PCNT_W=2 -> periods saturates at 3.
- DONE restart: from DONE (terminal=2), terminal=7 + start -> done=0, q restarts at 0, new terminal 7 honoured.

Source files
------------

// File: rtl/count_sequencer.sv
// count_sequencer: synchronous sequencer for a WIDTH-bit event counter.
// The counter runs from 0 up to a terminal value latched at start. Each
// terminal-count event pulses tc for one cycle. In periodic mode the count
// reloads to 0 and a saturating period counter advances. In one-shot mode the
// count parks at the terminal value in DONE.
//
// Ports:
//   clock     system clock, rising edge
//   clear     asynchronous active-low reset
//   start     begin a sequence (honoured in IDLE or DONE only)
//   halt      abort back to IDLE (highest priority)
//   hold      freeze counting while high (RUN/HOLD)
//   periodic  1 = reload at terminal, 0 = one-shot; sampled at each event
//   terminal  terminal count, latched on an accepted start
//   q         current count
//   busy      high in RUN or HOLD
//   tc        one-cycle pulse per terminal-count event
//   done      high while in DONE
//   periods   completed periodic wraps, saturating
module count_sequencer #(
  parameter int WIDTH  = 4,
  parameter int PCNT_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              halt,
  input  logic              hold,
  input  logic              periodic,
  input  logic [WIDTH-1:0]  terminal,
  output logic [WIDTH-1:0]  q,
  output logic              busy,
  output logic              tc,
  output logic              done,
  output logic [PCNT_W-1:0] periods
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] term_r;
  logic             per_max;

  assign per_max = &periods;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      q       <= '0;
      term_r  <= '0;
      periods <= '0;
      tc      <= 1'b0;
    end else begin
      // tc is a pulse: only the terminal branch below re-asserts it.
      tc <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (halt) begin
            state <= IDLE;
            q     <= '0;
          end else if (start) begin
            state   <= RUN;
            q       <= '0;
            term_r  <= terminal;
            periods <= '0;
          end
        end
        RUN: begin
          if (halt) begin
            state <= IDLE;
            q     <= '0;
          end else if (hold) begin
            state <= HOLD;
          end else if (q == term_r) begin
            tc <= 1'b1;
            if (periodic) begin
              // Reload explicitly so a terminal below all-ones still wraps to 0.
              q <= '0;
              if (!per_max) periods <= periods + 1'b1;
            end else begin
              state <= DONE;
            end
          end else begin
            q <= q + 1'b1;
          end
        end
        HOLD: begin
          if (halt) begin
            state <= IDLE;
            q     <= '0;
          end else if (!hold) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags come straight from the state register.
  assign busy = (state == RUN) || (state == HOLD);
  assign done = (state == DONE);

endmodule
